// File: rtl/forward_hazard_unit.sv
// ============================================================================
// Module   : forward_hazard_unit
// Purpose  : Data-forwarding select generation and load-use stall detection
//            for a classic five-stage pipeline. Tracks the EX and MEM stage
//            destination info internally and registers FwdA/FwdB so they
//            are valid throughout the cycle the consumer occupies EX.
// Options  : FWD_HAZARD_STATS_EN adds a saturating 16-bit StallCount output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_hazard_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ID_Valid,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic [4:0] ID_Rd,
  input  logic       ID_RegWrite,
  input  logic       ID_MemRead,
  input  logic       Flush,
  output logic [1:0] FwdA,
  output logic [1:0] FwdB,
  output logic       Stall
`ifdef FWD_HAZARD_STATS_EN
  ,output logic [15:0] StallCount
`endif
);

  localparam logic [1:0] C_SEL_RF  = 2'd0;
  localparam logic [1:0] C_SEL_EX  = 2'd1;
  localparam logic [1:0] C_SEL_MEM = 2'd2;

  // EX-stage tracking state
  logic       ex_valid_q,    ex_valid_d;
  logic [4:0] ex_rd_q,       ex_rd_d;
  logic       ex_regwrite_q, ex_regwrite_d;
  logic       ex_memread_q,  ex_memread_d;
  // MEM-stage tracking state
  logic       mem_valid_q,    mem_valid_d;
  logic [4:0] mem_rd_q,       mem_rd_d;
  logic       mem_regwrite_q, mem_regwrite_d;
  // Registered forwarding selects
  logic [1:0] fwda_q, fwda_d;
  logic [1:0] fwdb_q, fwdb_d;

  logic ex_writes, mem_writes;
  logic ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;
  logic stall_w;
  logic advance;

  // Which older stage produces each of the ID operands, plus load-use detection
  always_comb begin
    ex_writes  = ex_valid_q  & ex_regwrite_q  & (ex_rd_q  != 5'd0);
    mem_writes = mem_valid_q & mem_regwrite_q & (mem_rd_q != 5'd0);
    ex_wr_rs   = ex_writes  & (ex_rd_q  == ID_Rs);
    ex_wr_rt   = ex_writes  & (ex_rd_q  == ID_Rt) & ID_UsesRt;
    mem_wr_rs  = mem_writes & (mem_rd_q == ID_Rs);
    mem_wr_rt  = mem_writes & (mem_rd_q == ID_Rt) & ID_UsesRt;
    // A load in EX cannot supply its data yet; hold ID for one cycle so the
    // value arrives via MEM/WB. Flush squashes ID, so no stall is needed.
    stall_w    = ID_Valid & ex_valid_q & ex_memread_q & (ex_rd_q != 5'd0) &
                 ((ex_rd_q == ID_Rs) | (ID_UsesRt & (ex_rd_q == ID_Rt))) &
                 ~Flush;
    // Only a real, unsquashed, unstalled instruction moves into EX.
    advance    = ID_Valid & ~Flush & ~stall_w;
  end

  // Next-state for the pipeline mirror and the forwarding selects
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_rd_d        = 5'd0;
    ex_regwrite_d  = 1'b0;
    ex_memread_d   = 1'b0;
    fwda_d         = C_SEL_RF;
    fwdb_d         = C_SEL_RF;
    // MEM always takes the previous EX contents (including on stall/flush).
    mem_valid_d    = ex_valid_q;
    mem_rd_d       = ex_rd_q;
    mem_regwrite_d = ex_regwrite_q;
    if (advance) begin
      ex_valid_d    = 1'b1;
      ex_rd_d       = ID_Rd;
      ex_regwrite_d = ID_RegWrite;
      ex_memread_d  = ID_MemRead;
      // EX is the younger producer, so it wins over MEM.
      if (ex_wr_rs)       fwda_d = C_SEL_EX;
      else if (mem_wr_rs) fwda_d = C_SEL_MEM;
      if (ex_wr_rt)       fwdb_d = C_SEL_EX;
      else if (mem_wr_rt) fwdb_d = C_SEL_MEM;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      fwda_q         <= C_SEL_RF;
      fwdb_q         <= C_SEL_RF;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      fwda_q         <= fwda_d;
      fwdb_q         <= fwdb_d;
    end
  end

  assign FwdA  = fwda_q;
  assign FwdB  = fwdb_q;
  assign Stall = stall_w;

`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stall cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Counter register, cleared by reset
  always_ff @(posedge Clk) begin
    if (Reset) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
// ============================================================================
// Module   : tb_forward_hazard_unit
// Purpose  : Self-checking bench for forward_hazard_unit: directed hazard
//            scenarios followed by randomized instruction streams, compared
//            against an instruction-level pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rt, id_regwrite, id_memread, flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stall_count;
`endif

  forward_hazard_unit dut (
    .Clk         (clk),
    .Reset       (rst),
    .ID_Valid    (id_valid),
    .ID_Rs       (id_rs),
    .ID_Rt       (id_rt),
    .ID_UsesRt   (id_uses_rt),
    .ID_Rd       (id_rd),
    .ID_RegWrite (id_regwrite),
    .ID_MemRead  (id_memread),
    .Flush       (flush),
    .FwdA        (fwd_a),
    .FwdB        (fwd_b),
    .Stall       (stall)
`ifdef FWD_HAZARD_STATS_EN
    ,.StallCount (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model (instruction level) ----------------
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } instr_t;

  instr_t pipe [2];   // index 0 = EX, index 1 = MEM (age order)
  int     m_fa, m_fb, m_cnt;
  int     n_cmp, n_err;
  bit     last_stall;

  function automatic int producer(input int r);
    if (r == 0) return 0;
    for (int s = 0; s < 2; s++)
      if (pipe[s].v && pipe[s].rw && pipe[s].rd == r[4:0]) return s + 1;
    return 0;
  endfunction

  function automatic bit model_stall(input bit v, input int rs, input int rt,
                                     input bit ur, input bit fl);
    if (!v || fl || !pipe[0].v || !pipe[0].mr || pipe[0].rd == 0) return 0;
    return (pipe[0].rd == rs[4:0]) || (ur && pipe[0].rd == rt[4:0]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive ID, check Stall, clock, update model, check selects.
  task automatic step(input bit v, input int rs, input int rt, input bit ur,
                      input int rd, input bit rw, input bit mr,
                      input bit fl, input bit rs_t);
    bit     s;
    instr_t n;
    @(negedge clk);
    id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_uses_rt = ur;
    id_rd = rd[4:0]; id_regwrite = rw; id_memread = mr; flush = fl; rst = rs_t;
    #1;
    s = model_stall(v, rs, rt, ur, fl);
    last_stall = stall;
    chk("stall", int'(stall), int'(s));
    @(posedge clk);
    if (rs_t) begin
      pipe[0] = '{0, 0, 0, 0};
      pipe[1] = '{0, 0, 0, 0};
      m_fa = 0; m_fb = 0; m_cnt = 0;
    end else begin
      if (v && !fl && !s) begin
        m_fa = producer(rs);
        m_fb = ur ? producer(rt) : 0;
        n = '{1, rd[4:0], rw, mr};
      end else begin
        m_fa = 0; m_fb = 0;
        n = '{0, 0, 0, 0};
      end
      pipe[1] = pipe[0];
      pipe[0] = n;
      if (s && m_cnt < 65535) m_cnt++;
    end
    #1;
    chk("fwd_a", int'(fwd_a), m_fa);
    chk("fwd_b", int'(fwd_b), m_fb);
    // An EX/MEM-sourced operand must never come from a load.
    chk("no_load_fwd1", int'((fwd_a == 2'd1 || fwd_b == 2'd1) && pipe[1].mr), 0);
`ifdef FWD_HAZARD_STATS_EN
    chk("stall_count", int'(stall_count), m_cnt);
`endif
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_cnt = 0; m_fa = 0; m_fb = 0;
    pipe[0] = '{0, 0, 0, 0};
    pipe[1] = '{0, 0, 0, 0};
    rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0;

    // Reset state
    do_reset();
    chk("rst_fwd_a", int'(fwd_a), 0);
    chk("rst_fwd_b", int'(fwd_b), 0);
    chk("rst_stall", int'(stall), 0);

    // Back-to-back: add $8 ; sub $12,$8,$3
    step(1, 1, 2, 1, 8, 1, 0, 0, 0);
    step(1, 8, 3, 1, 12, 1, 0, 0, 0);
    chk("b2b_fwd_a", int'(fwd_a), 1);
    chk("b2b_fwd_b", int'(fwd_b), 0);

    // Distance two, UsesRt=1 then UsesRt=0
    do_reset();
    step(1, 1, 2, 1, 9, 1, 0, 0, 0);
    step(1, 1, 2, 1, 13, 1, 0, 0, 0);
    step(1, 4, 9, 1, 14, 1, 0, 0, 0);
    chk("dist2_fwd_b", int'(fwd_b), 2);
    do_reset();
    step(1, 1, 2, 1, 9, 1, 0, 0, 0);
    step(1, 1, 2, 1, 13, 1, 0, 0, 0);
    step(1, 4, 9, 0, 14, 1, 0, 0, 0);
    chk("dist2_nort_fwd_b", int'(fwd_b), 0);

    // EX beats MEM on the same register; $0 is never forwarded
    do_reset();
    step(1, 1, 2, 1, 10, 1, 0, 0, 0);
    step(1, 1, 2, 1, 10, 1, 0, 0, 0);
    step(1, 10, 2, 1, 15, 1, 0, 0, 0);
    chk("prio_fwd_a", int'(fwd_a), 1);
    step(1, 1, 2, 1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 16, 1, 0, 0, 0);
    chk("r0_fwd_a", int'(fwd_a), 0);
    chk("r0_fwd_b", int'(fwd_b), 0);

    // Load-use: one stall, a bubble, then MEM/WB forward
    do_reset();
    step(1, 1, 2, 1, 11, 1, 1, 0, 0);
    step(1, 11, 3, 1, 17, 1, 0, 0, 0);
    chk("lu_stall", int'(last_stall), 1);
    chk("lu_bubble_fwd_a", int'(fwd_a), 0);
    step(1, 11, 3, 1, 17, 1, 0, 0, 0);
    chk("lu_stall_once", int'(last_stall), 0);
    chk("lu_fwd_a", int'(fwd_a), 2);
`ifdef FWD_HAZARD_STATS_EN
    chk("lu_count", int'(stall_count), 1);
`endif

    // Flush during a load-use hazard
    do_reset();
    step(1, 1, 2, 1, 11, 1, 1, 0, 0);
    step(1, 11, 11, 1, 17, 1, 0, 1, 0);
    chk("flush_stall", int'(last_stall), 0);
    chk("flush_fwd_a", int'(fwd_a), 0);
    chk("flush_fwd_b", int'(fwd_b), 0);

    // Reset mid-stall
    do_reset();
    step(1, 1, 2, 1, 11, 1, 1, 0, 0);
    step(1, 11, 3, 1, 17, 1, 0, 0, 1);
    chk("rstmid_was_stall", int'(last_stall), 1);
    step(1, 11, 3, 1, 17, 1, 0, 0, 0);
    chk("rstmid_stall", int'(last_stall), 0);
    chk("rstmid_fwd_a", int'(fwd_a), 0);
    chk("rstmid_fwd_b", int'(fwd_b), 0);
`ifdef FWD_HAZARD_STATS_EN
    chk("rstmid_count", int'(stall_count), 0);
`endif

    // Randomized streams over a small register set to provoke hazards
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) != 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)),
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
